// File: rtl/tlc_pkg.sv
// Shared types and helpers for the N-way traffic-light controller.
package tlc_pkg;

    // Widest approach count supported by the controller.
    localparam int MAX_DIR = 16;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

    // One-hot decode of idx; bits at or above n are never set.
    function automatic logic [MAX_DIR-1:0] onehot(input int idx, input int n);
        logic [MAX_DIR-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIR; i++) begin
            if (i == idx && i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Round-robin picker: first requesting approach after 'last', never 'last' itself.
module tlc_rr_arbiter #(
    parameter int N_DIR = 4
) (
    input  logic [N_DIR-1:0]         req,
    input  logic [$clog2(N_DIR)-1:0] last,
    output logic [$clog2(N_DIR)-1:0] grant_idx,
    output logic                     grant_vld
);

    localparam int IDX_W = $clog2(N_DIR);

    // Scan from the farthest offset down so the nearest requester after 'last' wins.
    always_comb begin
        int j;
        grant_idx = '0;
        grant_vld = 1'b0;
        j         = 0;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            j = (int'(last) + k) % N_DIR;
            if (req[j]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/traffic_light_controller_nway.sv
// Moore traffic-light controller for N_DIR approaches served round-robin on demand.
// Each hand-over runs GREEN -> YELLOW -> ALLRED; green rests while nobody else waits.
module traffic_light_controller_nway
    import tlc_pkg::*;
#(
    parameter int N_DIR     = 4,
    parameter int W_CNT     = 8,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 1,
    parameter int ALLRED_T  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [N_DIR-1:0]         sense,
    output logic [N_DIR-1:0]         red,
    output logic [N_DIR-1:0]         yellow,
    output logic [N_DIR-1:0]         green,
    output logic [$clog2(N_DIR)-1:0] active_dir,
    output logic [1:0]               phase
);

    localparam int     IDX_W   = $clog2(N_DIR);
    localparam longint CNT_LIM = 64'd1 << W_CNT;

    // Timer thresholds sized to the widened increment so compares never wrap.
    localparam logic [W_CNT:0] GMIN_C = (W_CNT+1)'(GREEN_MIN);
    localparam logic [W_CNT:0] GMAX_C = (W_CNT+1)'(GREEN_MAX);
    localparam logic [W_CNT:0] YEL_C  = (W_CNT+1)'(YELLOW_T);
    localparam logic [W_CNT:0] ARED_C = (W_CNT+1)'(ALLRED_T);

    generate
        if (N_DIR < 2 || N_DIR > MAX_DIR) begin : g_bad_ndir
            $error("traffic_light_controller_nway: N_DIR must be 2..16");
        end
        if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN) begin : g_bad_green
            $error("traffic_light_controller_nway: need 1 <= GREEN_MIN <= GREEN_MAX");
        end
        if (YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_zero
            $error("traffic_light_controller_nway: YELLOW_T and ALLRED_T must be >= 1");
        end
        if (longint'(GREEN_MIN) >= CNT_LIM || longint'(GREEN_MAX) >= CNT_LIM ||
            longint'(YELLOW_T)  >= CNT_LIM || longint'(ALLRED_T)  >= CNT_LIM) begin : g_bad_width
            $error("traffic_light_controller_nway: a phase time does not fit in W_CNT bits");
        end
    endgenerate

    phase_t             phase_r, phase_nx;
    logic [IDX_W-1:0]   dir_r, dir_nx;
    logic [IDX_W-1:0]   nxt_r, nxt_nx;
    logic [W_CNT-1:0]   cnt_r, cnt_nx;
    logic [W_CNT:0]     c1;
    logic [N_DIR-1:0]   own_mask;
    logic               own_sense;
    logic               other_dem;
    logic [IDX_W-1:0]   pick_idx;

    assign c1        = {1'b0, cnt_r} + (W_CNT+1)'(1);
    assign own_mask  = N_DIR'(onehot(int'(dir_r), N_DIR));
    assign own_sense = |(sense & own_mask);

    // The arbiter's valid doubles as "someone other than the owner is waiting".
    tlc_rr_arbiter #(.N_DIR(N_DIR)) u_arb (
        .req       (sense),
        .last      (dir_r),
        .grant_idx (pick_idx),
        .grant_vld (other_dem)
    );

    // State register: phase, owner, latched successor and phase timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= PH_GREEN;
            dir_r   <= '0;
            nxt_r   <= '0;
            cnt_r   <= '0;
        end else begin
            phase_r <= phase_nx;
            dir_r   <= dir_nx;
            nxt_r   <= nxt_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Next-state logic; nothing moves on cycles without a tick.
    always_comb begin
        phase_nx = phase_r;
        dir_nx   = dir_r;
        nxt_nx   = nxt_r;
        cnt_nx   = cnt_r;
        if (tick) begin
            case (phase_r)
                PH_GREEN: begin
                    if (c1 >= GMIN_C && other_dem && (!own_sense || c1 >= GMAX_C)) begin
                        phase_nx = PH_YELLOW;
                        cnt_nx   = '0;
                        nxt_nx   = pick_idx;
                    end else begin
                        // Saturate so an idle resting green never wraps the timer.
                        cnt_nx = (c1 >= GMAX_C) ? GMAX_C[W_CNT-1:0] : c1[W_CNT-1:0];
                    end
                end
                PH_YELLOW: begin
                    if (c1 == YEL_C) begin
                        phase_nx = PH_ALLRED;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = c1[W_CNT-1:0];
                    end
                end
                PH_ALLRED: begin
                    if (c1 == ARED_C) begin
                        phase_nx = PH_GREEN;
                        dir_nx   = nxt_r;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = c1[W_CNT-1:0];
                    end
                end
                default: begin
                    phase_nx = PH_GREEN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Lamp decode from state only; red is everything not green or yellow.
    always_comb begin
        green  = '0;
        yellow = '0;
        case (phase_r)
            PH_GREEN:  green  = own_mask;
            PH_YELLOW: yellow = own_mask;
            default:   ;
        endcase
        red = ~(green | yellow);
    end

    assign active_dir = dir_r;
    assign phase      = phase_r;

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// Directed bench for the 4-way controller with default timing.
module tb_traffic_light_controller_nway;

    localparam int N_DIR     = 4;
    localparam int GREEN_MIN = 5;
    localparam int YELLOW_T  = 1;
    localparam int ALLRED_T  = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] sense = 4'b0000;
    logic [3:0] red, yellow, green;
    logic [1:0] active_dir;
    logic [1:0] phase;

    int errors = 0;
    int checks = 0;

    traffic_light_controller_nway #(
        .N_DIR(4), .W_CNT(8), .GREEN_MIN(5), .GREEN_MAX(20), .YELLOW_T(1), .ALLRED_T(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .sense      (sense),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_dir (active_dir),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges and releases it just after an edge: that cycle is cycle 0.
    task automatic apply_reset;
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        sense = 4'b0000;
        tick  = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if (green !== 4'b0001 || yellow !== 4'b0000 || red !== 4'b1110 || phase !== 2'd0 || active_dir !== 2'd0) begin
            errors++;
            $display("FAIL reset_async g=%b y=%b r=%b ph=%0d dir=%0d want g=0001 y=0000 r=1110 ph=0 dir=0",
                     green, yellow, red, phase, active_dir);
        end
        step;
        step;
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (green !== 4'b0001 || red !== 4'b1110 || yellow !== 4'b0000 || phase !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle c=%0d g=%b r=%b y=%b ph=%0d want g=0001 r=1110 y=0000 ph=0",
                         c, green, red, yellow, phase);
            end
            step;
        end
    endtask

    task automatic test_min_green;
        logic [3:0] eg, ey;
        logic [1:0] ed;
        sense = 4'b0100;
        tick  = 1'b1;
        apply_reset;
        for (int c = 0; c <= 9; c++) begin
            eg = (c <= 4) ? 4'b0001 : (c >= 7) ? 4'b0100 : 4'b0000;
            ey = (c == 5) ? 4'b0001 : 4'b0000;
            ed = (c >= 7) ? 2'd2 : 2'd0;
            checks++;
            if (green !== eg || yellow !== ey || red !== ~(eg | ey) || active_dir !== ed) begin
                errors++;
                $display("FAIL min_green c=%0d g=%b y=%b r=%b dir=%0d want g=%b y=%b dir=%0d",
                         c, green, yellow, red, active_dir, eg, ey, ed);
            end
            step;
        end
    endtask

    task automatic test_max_green;
        logic [3:0] eg, ey;
        logic [1:0] ep;
        sense = 4'b0011;
        tick  = 1'b1;
        apply_reset;
        for (int c = 0; c <= 24; c++) begin
            eg = (c <= 19) ? 4'b0001 : (c >= 22) ? 4'b0010 : 4'b0000;
            ey = (c == 20) ? 4'b0001 : 4'b0000;
            ep = (c == 20) ? 2'd1 : (c == 21) ? 2'd2 : 2'd0;
            checks++;
            if (green !== eg || yellow !== ey || phase !== ep) begin
                errors++;
                $display("FAIL max_green c=%0d g=%b y=%b ph=%0d want g=%b y=%b ph=%0d",
                         c, green, yellow, phase, eg, ey, ep);
            end
            step;
        end
    endtask

    task automatic test_rr_wrap;
        logic [3:0] eg, ey;
        logic [1:0] ed;
        sense = 4'b0100;
        tick  = 1'b1;
        apply_reset;
        for (int c = 0; c < 7; c++) step;
        sense = 4'b0011;
        for (int c = 7; c <= 22; c++) begin
            eg = (c <= 11) ? 4'b0100 : (c >= 14 && c <= 18) ? 4'b0001 : (c >= 21) ? 4'b0010 : 4'b0000;
            ey = (c == 12) ? 4'b0100 : (c == 19) ? 4'b0001 : 4'b0000;
            ed = (c <= 13) ? 2'd2 : (c <= 20) ? 2'd0 : 2'd1;
            checks++;
            if (green !== eg || yellow !== ey || active_dir !== ed) begin
                errors++;
                $display("FAIL rr_wrap c=%0d g=%b y=%b dir=%0d want g=%b y=%b dir=%0d",
                         c, green, yellow, active_dir, eg, ey, ed);
            end
            if (c == 12) sense = 4'b0010;
            step;
        end
    endtask

    task automatic test_slow_tick_and_reset;
        logic [3:0] eg, ey;
        logic [1:0] ep;
        sense = 4'b1000;
        tick  = 1'b0;
        apply_reset;
        for (int c = 0; c <= 49; c++) begin
            tick = (c % 4 == 3);
            eg = (c <= 19) ? 4'b0001 : (c >= 28 && c <= 47) ? 4'b1000 : 4'b0000;
            ey = (c >= 20 && c <= 23) ? 4'b0001 : (c >= 48) ? 4'b1000 : 4'b0000;
            ep = (eg != 4'b0000) ? 2'd0 : (ey != 4'b0000) ? 2'd1 : 2'd2;
            checks++;
            if (green !== eg || yellow !== ey || phase !== ep) begin
                errors++;
                $display("FAIL slow_tick c=%0d g=%b y=%b ph=%0d want g=%b y=%b ph=%0d",
                         c, green, yellow, phase, eg, ey, ep);
            end
            if (c == 28) sense = 4'b0001;
            if (c < 49) step;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (green !== 4'b0001 || yellow !== 4'b0000 || red !== 4'b1110 || phase !== 2'd0 || active_dir !== 2'd0) begin
            errors++;
            $display("FAIL mid_yellow_reset g=%b y=%b r=%b ph=%0d dir=%0d want g=0001 y=0000 r=1110 ph=0 dir=0",
                     green, yellow, red, phase, active_dir);
        end
        sense = 4'b1000;
        tick  = 1'b1;
        step;
        step;
        reset = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            eg = (c <= 4) ? 4'b0001 : (c == 7) ? 4'b1000 : 4'b0000;
            ey = (c == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (green !== eg || yellow !== ey) begin
                errors++;
                $display("FAIL restart_timer c=%0d g=%b y=%b want g=%b y=%b", c, green, yellow, eg, ey);
            end
            step;
        end
    endtask

    task automatic test_random;
        logic [1:0] pp, pd;
        logic       t;
        int         gc, yc, ac;
        logic       legal;
        sense = 4'b0000;
        tick  = 1'b1;
        apply_reset;
        gc = 0;
        yc = 0;
        ac = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) sense = 4'($urandom_range(0, 15));
            tick = 1'($urandom_range(0, 1));
            pp = phase;
            pd = active_dir;
            t  = tick;
            step;
            if (t) begin
                if (pp == 2'd0) gc++;
                if (pp == 2'd1) yc++;
                if (pp == 2'd2) ac++;
            end
            checks++;
            if ($countones(green | yellow) > 1 || red !== ~(green | yellow) || active_dir >= 2'(N_DIR - 1) + 2'd1 && N_DIR < 4) begin
                errors++;
                $display("FAIL rand_lamps i=%0d g=%b y=%b r=%b dir=%0d", i, green, yellow, red, active_dir);
            end
            checks++;
            if (active_dir !== pd && !(pp == 2'd2 && phase == 2'd0)) begin
                errors++;
                $display("FAIL rand_dir_change i=%0d dir=%0d was %0d phase %0d->%0d", i, active_dir, pd, pp, phase);
            end
            if (phase !== pp) begin
                legal = t && ((pp == 2'd0 && phase == 2'd1) || (pp == 2'd1 && phase == 2'd2) ||
                              (pp == 2'd2 && phase == 2'd0));
                checks++;
                if (!legal) begin
                    errors++;
                    $display("FAIL rand_phase_seq i=%0d phase %0d->%0d tick=%0d", i, pp, phase, t);
                end
                checks++;
                if ((pp == 2'd0 && gc < GREEN_MIN) || (pp == 2'd1 && yc != YELLOW_T) ||
                    (pp == 2'd2 && ac != ALLRED_T)) begin
                    errors++;
                    $display("FAIL rand_phase_len i=%0d left phase %0d ticks g=%0d y=%0d a=%0d need g>=%0d y=%0d a=%0d",
                             i, pp, gc, yc, ac, GREEN_MIN, YELLOW_T, ALLRED_T);
                end
                gc = 0;
                yc = 0;
                ac = 0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_min_green;
        test_max_green;
        test_rr_wrap;
        test_slow_tick_and_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
